mux8_rr_sel_arbiter: RTL and testbench

//  Round-robin arbiter that shares one 8:1 1-bit mux datapath among 8 requesters.
//  - Each requester drives one mux input.
//  - The block picks the winner and drives the mux 3-bit select plus a one-hot grant.
//  - Limits burst length per grant.
//  - Sits between requesting units and the mux8 select tree in the ALU/pipeline datapath.

---
 rtl/mux8_rr_sel_arbiter.sv | 145 ++++++++++++++
 tb/tb_mux8_rr_sel_arbiter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/mux8_rr_sel_arbiter.sv
// Round-robin arbiter driving the 3-bit select and one-hot grant of a shared 8:1 mux.
// Define MUX_ARB_GUARD_EN to insert a one-cycle GUARD gap between a release and the next grant.
module mux8_rr_sel_arbiter #(
    parameter int NREQ     = 8,
    parameter int SEL_W    = 3,
    parameter int HOLD_MAX = 4,
    parameter int CNT_W    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  req,
    output logic [SEL_W-1:0] sel,
    output logic [NREQ-1:0]  gnt,
    output logic             gnt_valid,
    output logic [1:0]       dbg_state
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
`ifdef MUX_ARB_GUARD_EN
    localparam logic [1:0] ST_GUARD = 2'd2;
`endif
    localparam logic [CNT_W-1:0] HOLD_LAST = (HOLD_MAX == 0) ? '0 : CNT_W'(HOLD_MAX - 1);
    localparam logic [NREQ-1:0]  ONE       = {{(NREQ-1){1'b0}}, 1'b1};

    logic [1:0]       state_q, state_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             gnt_valid_q, gnt_valid_d;

    logic             win_found;
    logic [SEL_W-1:0] win_idx;
    logic [SEL_W-1:0] cand;
    logic             cur_req;
    logic             others_req;
    logic             timeout;
    logic             release_g;

    // Search ptr+1 .. ptr+8 (mod 8); the grantee itself is examined last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_q;
        cand      = ptr_q;
        for (int i = 1; i <= NREQ; i++) begin
            cand = ptr_q + SEL_W'(i);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        cur_req    = req[sel_q];
        others_req = |(req & ~gnt_q);
        timeout    = (HOLD_MAX != 0) && (hold_cnt_q == HOLD_LAST);
        release_g  = !cur_req || (timeout && others_req);
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        sel_d      = sel_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d    = ST_GRANT;
                    gnt_d      = ONE << win_idx;
                    sel_d      = win_idx;
                    ptr_d      = win_idx;
                    hold_cnt_d = '0;
                end
            end
            ST_GRANT: begin
                if (release_g) begin
                    if (win_found) begin
`ifdef MUX_ARB_GUARD_EN
                        state_d = ST_GUARD;
                        gnt_d   = '0;
`else
                        gnt_d      = ONE << win_idx;
                        sel_d      = win_idx;
                        ptr_d      = win_idx;
                        hold_cnt_d = '0;
`endif
                    end else begin
                        state_d = ST_IDLE;
                        gnt_d   = '0;
                    end
                end else if (timeout) begin
                    // Sole requester at its limit keeps the grant; the burst restarts.
                    hold_cnt_d = '0;
                end else if (hold_cnt_q != HOLD_LAST) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
`ifdef MUX_ARB_GUARD_EN
            ST_GUARD: begin
                if (win_found) begin
                    state_d    = ST_GRANT;
                    gnt_d      = ONE << win_idx;
                    sel_d      = win_idx;
                    ptr_d      = win_idx;
                    hold_cnt_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
        gnt_valid_d = (state_d == ST_GRANT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            sel_q       <= '0;
            ptr_q       <= SEL_W'(NREQ - 1);
            hold_cnt_q  <= '0;
            gnt_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            sel_q       <= sel_d;
            ptr_q       <= ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            gnt_valid_q <= gnt_valid_d;
        end
    end

    assign gnt       = gnt_q;
    assign sel       = sel_q;
    assign gnt_valid = gnt_valid_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mux8_rr_sel_arbiter.sv
// Directed bench for mux8_rr_sel_arbiter: reset, single requester, rotation, wrap, early release, async reset.
module tb_mux8_rr_sel_arbiter;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [2:0] sel;
    logic [7:0] gnt;
    logic       gnt_valid;
    logic [1:0] dbg_state;

    int n_cmp;
    int n_err;

`ifdef MUX_ARB_GUARD_EN
    logic [2:0] last_sel;
`endif

    mux8_rr_sel_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .sel       (sel),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(string tag, logic [7:0] eg, logic [2:0] es, logic ev);
        n_cmp++;
        assert (gnt === eg) else begin
            n_err++;
            $error("FAIL %s gnt got=%h exp=%h", tag, gnt, eg);
        end
        n_cmp++;
        assert (sel === es) else begin
            n_err++;
            $error("FAIL %s sel got=%0d exp=%0d", tag, sel, es);
        end
        n_cmp++;
        assert (gnt_valid === ev) else begin
            n_err++;
            $error("FAIL %s gnt_valid got=%b exp=%b", tag, gnt_valid, ev);
        end
`ifdef MUX_ARB_GUARD_EN
        last_sel = es;
`endif
    endtask

    task automatic handoff(string tag, logic [7:0] eg, logic [2:0] es);
`ifdef MUX_ARB_GUARD_EN
        step();
        check_out({tag, "_gap"}, 8'h00, last_sel, 1'b0);
`endif
        step();
        check_out(tag, eg, es, 1'b1);
    endtask

    task automatic reset_dut();
        req   = 8'h00;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        req   = 8'hFF;

        // Reset held with every requester active
        step();
        step();
        check_out("rst_hold", 8'h00, 3'd0, 1'b0);
        rst_n = 1'b1;
        step();
        check_out("rst_first", 8'h01, 3'd0, 1'b1);

        // All 8 requesting: 4-cycle bursts rotating 0..7 then back to 0
        for (int r = 0; r < 9; r++) begin
            logic [7:0] eg;
            logic [2:0] es;
            es = 3'(r % 8);
            eg = 8'h01 << es;
            for (int c = 0; c < 4; c++) begin
                check_out("rot", eg, es, 1'b1);
                step();
            end
`ifdef MUX_ARB_GUARD_EN
            check_out("rot_gap", 8'h00, es, 1'b0);
            step();
`endif
        end

        // Single requester 5 held across several hold-limit periods
        reset_dut();
        req = 8'h20;
        step();
        for (int c = 0; c < 10; c++) begin
            check_out("single", 8'h20, 3'd5, 1'b1);
            step();
        end
        req = 8'h00;
        step();
        check_out("single_drop", 8'h00, 3'd5, 1'b0);
        step();
        check_out("idle_sel_hold", 8'h00, 3'd5, 1'b0);

        // Wrap: from grantee 7 the next search starts at 0
        reset_dut();
        req = 8'h80;
        step();
        check_out("wrap_g7", 8'h80, 3'd7, 1'b1);
        req = 8'h81;
        for (int c = 0; c < 3; c++) begin
            step();
            check_out("wrap_hold7", 8'h80, 3'd7, 1'b1);
        end
        handoff("wrap_to0", 8'h01, 3'd0);
        req = 8'h01;
        step();
        check_out("wrap_g0", 8'h01, 3'd0, 1'b1);
        req = 8'h80;
        handoff("wrap_back7", 8'h80, 3'd7);
        req = 8'h00;
        step();
        check_out("wrap_idle", 8'h00, 3'd7, 1'b0);

        // Early release: requester 2 drops after two grant cycles
        reset_dut();
        req = 8'h0C;
        step();
        check_out("early_g2a", 8'h04, 3'd2, 1'b1);
        step();
        check_out("early_g2b", 8'h04, 3'd2, 1'b1);
        req = 8'h08;
        handoff("early_to3", 8'h08, 3'd3);
        req = 8'h00;
        step();
        check_out("early_idle", 8'h00, 3'd3, 1'b0);

        // Asynchronous reset between edges while requester 4 holds the grant
        reset_dut();
        req = 8'h10;
        step();
        check_out("async_g4a", 8'h10, 3'd4, 1'b1);
        step();
        check_out("async_g4b", 8'h10, 3'd4, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async_clear", 8'h00, 3'd0, 1'b0);
        step();
        check_out("async_hold", 8'h00, 3'd0, 1'b0);
        req   = 8'hFF;
        rst_n = 1'b1;
        step();
        check_out("async_restart", 8'h01, 3'd0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
